// File: rtl/fetch_pkg.sv
// Shared definitions for the instruction fetch controller: FSM encoding,
// opcode field position and the HALT / NOP encodings.
package fetch_pkg;

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_FETCH  = 2'd1;
    localparam logic [1:0] ST_HALTED = 2'd2;

    typedef enum logic [1:0] {
        IDLE   = ST_IDLE,
        FETCH  = ST_FETCH,
        HALTED = ST_HALTED
    } fetch_state_e;

    localparam int OPC_LSB = 0;
    localparam int OPC_MSB = 6;
    localparam int OPC_W   = OPC_MSB - OPC_LSB + 1;

    localparam logic [OPC_W-1:0] HALT_OPC = 7'b1010101;
    localparam logic [31:0]      NOP      = 32'b0;

endpackage

// File: rtl/fetch_skid_buf.sv
// Two-entry FIFO of {pc, instr} between the memory read port and decode.
// Storage is not reset; only the pointers and occupancy are.
module fetch_skid_buf #(
    parameter int ADDR_W = 5,
    parameter int DATA_W = 32
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              push_i,
    input  logic [ADDR_W-1:0] push_pc_i,
    input  logic [DATA_W-1:0] push_instr_i,
    input  logic              pop_i,
    input  logic              flush_i,
    output logic [1:0]        occ_o,
    output logic [ADDR_W-1:0] head_pc_o,
    output logic [DATA_W-1:0] head_instr_o
);

    logic [ADDR_W-1:0] pc_q    [2];
    logic [DATA_W-1:0] instr_q [2];
    logic              wr_q, wr_d;
    logic              rd_q, rd_d;
    logic [1:0]        occ_q, occ_d;

    always_ff @(posedge clk_i) begin
        if (push_i && !flush_i) begin
            pc_q[wr_q]    <= push_pc_i;
            instr_q[wr_q] <= push_instr_i;
        end
    end

    always_comb begin
        wr_d  = wr_q;
        rd_d  = rd_q;
        occ_d = occ_q;
        if (flush_i) begin
            wr_d  = 1'b0;
            rd_d  = 1'b0;
            occ_d = 2'd0;
        end else begin
            if (push_i) wr_d = ~wr_q;
            if (pop_i)  rd_d = ~rd_q;
            occ_d = occ_q + {1'b0, push_i} - {1'b0, pop_i};
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_q  <= 1'b0;
            rd_q  <= 1'b0;
            occ_q <= 2'd0;
        end else begin
            wr_q  <= wr_d;
            rd_q  <= rd_d;
            occ_q <= occ_d;
        end
    end

    assign occ_o        = occ_q;
    assign head_pc_o    = pc_q[rd_q];
    assign head_instr_o = instr_q[rd_q];

endmodule

// File: rtl/fetch_controller.sv
// Program-memory fetch sequencer with HALT detection, PC redirect and a
// 2-entry skid buffer. Optional perf counters under FETCH_PERF_CNT_EN.
module fetch_controller #(
    parameter int          ADDR_W   = 5,
    parameter int          DATA_W   = 32,
    parameter logic [6:0]  HALT_OPC = fetch_pkg::HALT_OPC,
    parameter int unsigned RESET_PC = 0
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    output logic [ADDR_W-1:0] prog_addr,
    input  logic [DATA_W-1:0] mem_instr,
    output logic [DATA_W-1:0] instr,
    output logic [ADDR_W-1:0] instr_pc,
    output logic              instr_valid,
    input  logic              instr_ready,
    input  logic              redirect_valid,
    input  logic [ADDR_W-1:0] redirect_pc,
    output logic              halted,
    output logic              busy
`ifdef FETCH_PERF_CNT_EN
    ,
    output logic [15:0]       fetch_cnt,
    output logic [15:0]       stall_cnt
`endif
);
    import fetch_pkg::*;

    localparam logic [ADDR_W-1:0] RST_PC = ADDR_W'(RESET_PC);

    fetch_state_e      state_q, state_d;
    logic [ADDR_W-1:0] pc_q, pc_d;
    logic [ADDR_W-1:0] tag_q, tag_d;
    logic              inflight_q, inflight_d;
    logic              halt_seen_q, halt_seen_d;
    logic [DATA_W-1:0] instr_q;
    logic [ADDR_W-1:0] instr_pc_q;

    logic [1:0]        occ;
    logic [2:0]        pending;
    logic [ADDR_W-1:0] head_pc, issue_addr;
    logic [DATA_W-1:0] head_instr;
    logic              in_fetch, start_go, redir, pop, push, flush;
    logic              halt_xfer, cap_halt, issue;

    assign in_fetch  = (state_q == FETCH);
    assign start_go  = start && !in_fetch;
    assign redir     = redirect_valid && in_fetch;
    assign pop       = instr_valid && instr_ready;
    assign halt_xfer = pop && (head_instr[OPC_MSB:OPC_LSB] == HALT_OPC) && !redir;
    // Reads landing after a HALT capture or during a redirect are squashed.
    assign push      = in_fetch && inflight_q && !redir && !halt_seen_q;
    assign cap_halt  = push && (mem_instr[OPC_MSB:OPC_LSB] == HALT_OPC);
    assign flush     = redir || halt_xfer;
    assign pending   = {1'b0, occ} + {2'b0, inflight_q} - {2'b0, pop};

    // The memory registers prog_addr every edge, so a start or redirect
    // target is driven straight onto the address bus in the same cycle.
    always_comb begin
        issue      = 1'b0;
        issue_addr = pc_q;
        if (start_go) begin
            issue      = 1'b1;
            issue_addr = RST_PC;
        end else if (redir) begin
            issue      = 1'b1;
            issue_addr = redirect_pc;
        end else if (in_fetch && !halt_seen_q && pending <= 3'd1) begin
            issue = 1'b1;
        end
    end

    always_comb begin
        state_d     = state_q;
        pc_d        = issue ? issue_addr + ADDR_W'(1) : pc_q;
        inflight_d  = issue;
        tag_d       = issue ? issue_addr : tag_q;
        halt_seen_d = halt_seen_q;
        if (start_go || redir || halt_xfer) halt_seen_d = 1'b0;
        else if (cap_halt)                  halt_seen_d = 1'b1;
        case (state_q)
            IDLE, HALTED: if (start_go)  state_d = FETCH;
            FETCH:        if (halt_xfer) state_d = HALTED;
            default:                     state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= IDLE;
            pc_q        <= RST_PC;
            tag_q       <= '0;
            inflight_q  <= 1'b0;
            halt_seen_q <= 1'b0;
            instr_q     <= '0;
            instr_pc_q  <= '0;
        end else begin
            state_q     <= state_d;
            pc_q        <= pc_d;
            tag_q       <= tag_d;
            inflight_q  <= inflight_d;
            halt_seen_q <= halt_seen_d;
            instr_q     <= instr;
            instr_pc_q  <= instr_pc;
        end
    end

    fetch_skid_buf #(
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W)
    ) u_buf (
        .clk_i        (clk),
        .rst_ni       (reset),
        .push_i       (push),
        .push_pc_i    (tag_q),
        .push_instr_i (mem_instr),
        .pop_i        (pop),
        .flush_i      (flush),
        .occ_o        (occ),
        .head_pc_o    (head_pc),
        .head_instr_o (head_instr)
    );

    // Outputs hold the last presented word whenever the buffer is empty.
    assign instr_valid = (occ != 2'd0);
    assign instr       = instr_valid ? head_instr : instr_q;
    assign instr_pc    = instr_valid ? head_pc : instr_pc_q;
    assign prog_addr   = issue_addr;
    assign halted      = (state_q == HALTED);
    assign busy        = in_fetch;

`ifdef FETCH_PERF_CNT_EN
    function automatic logic [15:0] sat_inc(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

    logic [15:0] fetch_cnt_q, stall_cnt_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            fetch_cnt_q <= 16'd0;
            stall_cnt_q <= 16'd0;
        end else if (start_go) begin
            fetch_cnt_q <= 16'd0;
            stall_cnt_q <= 16'd0;
        end else begin
            if (pop)                         fetch_cnt_q <= sat_inc(fetch_cnt_q);
            if (instr_valid && !instr_ready) stall_cnt_q <= sat_inc(stall_cnt_q);
        end
    end

    assign fetch_cnt = fetch_cnt_q;
    assign stall_cnt = stall_cnt_q;
`endif

endmodule
